dac_seg_encoder: RTL and testbench

- Digital front-end feeding the segmented current-steering DAC core.
- Accepts a stream of DATA_W-bit sample codes, buffers them and releases one code per update period.
- Splits each code into binary LSB controls and unary thermometer MSB controls, and drives both true and complement buses from the same register stage.
- Also generates the code-ramp characterisation pattern and constant-code patterns on-chip.

---
 rtl/dac_enc_pkg.sv | 21 ++
 rtl/dac_seg_decoder.sv | 79 +++++++
 rtl/dac_seg_encoder.sv | 184 ++++++++++++++++++
 tb/tb_dac_seg_encoder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_enc_pkg.sv
// Shared definitions for the segmented DAC front-end: operating modes,
// default geometry and the unary segment width helper.
package dac_enc_pkg;

    typedef enum logic [1:0] {
        MODE_STREAM = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_CONST  = 2'd2
    } mode_e;

    localparam int DATA_W_DEF  = 10;
    localparam int BIN_W_DEF   = 7;
    localparam int THERM_W_DEF = 17;
    localparam int DEPTH_DEF   = 4;

    // Number of active thermometer cells for the unary-coded MSBs.
    function automatic int unary_width(input int data_w, input int bin_w);
        return (1 << (data_w - bin_w)) - 1;
    endfunction

endpackage

// File: rtl/dac_seg_decoder.sv
// Output stage: converts the registered code into binary LSB controls and
// thermometer MSB controls. True and complement buses share one register
// stage so every DAC switch toggles on the same clock edge.
module dac_seg_decoder
    import dac_enc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BIN_W   = BIN_W_DEF,
    parameter int THERM_W = THERM_W_DEF
) (
    input  logic               clkin,
    input  logic               rstb,
    input  logic [DATA_W-1:0]  code_in,
    input  logic               upd_in,
    output logic [BIN_W-1:0]   bin_out,
    output logic [BIN_W-1:0]   binb_out,
    output logic [THERM_W-1:0] therm_out,
    output logic [THERM_W-1:0] thermb_out,
    output logic [DATA_W-1:0]  code_out,
    output logic               upd_out
);

    localparam int M       = DATA_W - BIN_W;
    localparam int UNARY_W = unary_width(DATA_W, BIN_W);

    logic [M-1:0]       msb;
    logic [BIN_W-1:0]   bin_d, bin_q, binb_d, binb_q;
    logic [THERM_W-1:0] therm_d, therm_q, thermb_d, thermb_q;
    logic [DATA_W-1:0]  code_q;
    logic               upd_q;

    assign msb = code_in[DATA_W-1:BIN_W];

    // Cell gi is on when the MSB value exceeds its index; spare cells stay off.
    genvar gi;
    generate
        for (gi = 0; gi < THERM_W; gi++) begin : g_therm
            if (gi < UNARY_W) begin : g_active
                assign therm_d[gi] = (gi < int'(msb));
            end else begin : g_spare
                assign therm_d[gi] = 1'b0;
            end
        end
    endgenerate

    // Binary segment and complement values for the next register stage.
    always_comb begin
        bin_d    = code_in[BIN_W-1:0];
        binb_d   = ~code_in[BIN_W-1:0];
        thermb_d = ~therm_d;
    end

    // Single register stage for every bus so true/complement switch together.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            bin_q    <= '0;
            binb_q   <= '1;
            therm_q  <= '0;
            thermb_q <= '1;
            code_q   <= '0;
            upd_q    <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            binb_q   <= binb_d;
            therm_q  <= therm_d;
            thermb_q <= thermb_d;
            code_q   <= code_in;
            upd_q    <= upd_in;
        end
    end

    assign bin_out    = bin_q;
    assign binb_out   = binb_q;
    assign therm_out  = therm_q;
    assign thermb_out = thermb_q;
    assign code_out   = code_q;
    assign upd_out    = upd_q;

endmodule

// File: rtl/dac_seg_encoder.sv
// Segmented current-steering DAC front-end: sample FIFO, update-rate
// divider, stream/ramp/constant code selection and a two-stage output
// pipeline (select register, then decode register).
module dac_seg_encoder
    import dac_enc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BIN_W   = BIN_W_DEF,
    parameter int THERM_W = THERM_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clkin,
    input  logic               rstb,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [15:0]        div_ratio,
    input  logic [DATA_W-1:0]  const_code,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_code,
    input  logic               clr_flags,
    output logic [BIN_W-1:0]   datainbin,
    output logic [BIN_W-1:0]   datainbinb,
    output logic [THERM_W-1:0] dataintherm,
    output logic [THERM_W-1:0] datainthermb,
    output logic [DATA_W-1:0]  code_out,
    output logic               upd,
    output logic               underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Divider state; period_q holds the last count value of the running period.
    logic [15:0] div_cnt_q, div_cnt_d, period_q, period_d, period_new;
    logic        strobe;

    // FIFO state.
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              fifo_full, fifo_empty, push, pop;

    // Code select state (pipeline stage 1).
    logic              is_ramp, is_const, is_stream;
    logic              ramp_active_q, ramp_active_d;
    logic [DATA_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [DATA_W-1:0] code1_q, code1_d;
    logic              upd1_q, upd1_d;
    logic              underflow_q, underflow_d;

    assign is_ramp   = (mode == MODE_RAMP);
    assign is_const  = (mode == MODE_CONST);
    assign is_stream = !is_ramp && !is_const;

    // A new period length is only picked up at a period boundary or while idle.
    assign period_new = (div_ratio == 16'd0) ? 16'd0 : (div_ratio - 16'd1);
    assign strobe     = en && (div_cnt_q == period_q);

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign pop        = strobe && is_stream && !fifo_empty;
    // A full FIFO still accepts a code in the cycle its head is popped.
    assign s_ready    = rstb && en && (!fifo_full || pop);
    assign push       = s_valid && s_ready;

    // Divider counter and period latch.
    always_comb begin
        div_cnt_d = div_cnt_q + 16'd1;
        period_d  = period_q;
        if (!en || strobe) begin
            div_cnt_d = '0;
            period_d  = period_new;
        end
    end

    // FIFO pointers and occupancy; dropping en flushes everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Sample storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clkin) begin
        if (push) fifo_mem[wr_ptr_q] <= s_code;
    end

    // Code selection on the update strobe; a stream underflow holds the last code.
    always_comb begin
        ramp_active_d = ramp_active_q;
        ramp_cnt_d    = ramp_cnt_q;
        code1_d       = code1_q;
        upd1_d        = 1'b0;
        if (!en) begin
            ramp_active_d = 1'b0;
            ramp_cnt_d    = '0;
            code1_d       = '0;
        end else if (strobe) begin
            ramp_active_d = is_ramp;
            if (is_ramp) begin
                upd1_d = 1'b1;
                if (ramp_active_q) begin
                    code1_d    = ramp_cnt_q;
                    ramp_cnt_d = ramp_cnt_q + 1'b1;
                end else begin
                    code1_d    = '0;
                    ramp_cnt_d = DATA_W'(1);
                end
            end else if (is_const) begin
                code1_d = const_code;
                upd1_d  = 1'b1;
            end else if (!fifo_empty) begin
                code1_d = fifo_mem[rd_ptr_q];
                upd1_d  = 1'b1;
            end
        end
    end

    // Sticky underflow: a new event wins over a same-cycle clear.
    always_comb begin
        underflow_d = underflow_q;
        if (strobe && is_stream && fifo_empty) underflow_d = 1'b1;
        else if (clr_flags)                    underflow_d = 1'b0;
    end

    // State registers for divider, FIFO control, selection and flags.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            div_cnt_q     <= '0;
            period_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ramp_active_q <= 1'b0;
            ramp_cnt_q    <= '0;
            code1_q       <= '0;
            upd1_q        <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            period_q      <= period_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ramp_active_q <= ramp_active_d;
            ramp_cnt_q    <= ramp_cnt_d;
            code1_q       <= code1_d;
            upd1_q        <= upd1_d;
            underflow_q   <= underflow_d;
        end
    end

    assign underflow = underflow_q;

    dac_seg_decoder #(
        .DATA_W  (DATA_W),
        .BIN_W   (BIN_W),
        .THERM_W (THERM_W)
    ) u_decoder (
        .clkin      (clkin),
        .rstb       (rstb),
        .code_in    (code1_q),
        .upd_in     (upd1_q),
        .bin_out    (datainbin),
        .binb_out   (datainbinb),
        .therm_out  (dataintherm),
        .thermb_out (datainthermb),
        .code_out   (code_out),
        .upd_out    (upd)
    );

endmodule

// File: tb/tb_dac_seg_encoder.sv
// Bench for dac_seg_encoder: a behavioural model (sample queue, period
// counter, two-cycle output delay) predicts every output each cycle.
module tb_dac_seg_encoder;

    localparam int DEPTH = 4;

    logic        clkin = 1'b0;
    logic        rstb, en, s_valid, clr_flags;
    logic [1:0]  mode;
    logic [15:0] div_ratio;
    logic [9:0]  const_code, s_code;
    logic        s_ready, upd, underflow;
    logic [6:0]  datainbin, datainbinb;
    logic [16:0] dataintherm, datainthermb;
    logic [9:0]  code_out;

    always #5 clkin = ~clkin;

    dac_seg_encoder dut (
        .clkin(clkin), .rstb(rstb), .en(en), .mode(mode), .div_ratio(div_ratio),
        .const_code(const_code), .s_valid(s_valid), .s_ready(s_ready), .s_code(s_code),
        .clr_flags(clr_flags), .datainbin(datainbin), .datainbinb(datainbinb),
        .dataintherm(dataintherm), .datainthermb(datainthermb), .code_out(code_out),
        .upd(upd), .underflow(underflow)
    );

    wire [59:0] got_vec = {code_out, upd, underflow, datainbin, datainbinb, dataintherm, datainthermb};

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state.
    int m_cnt, m_period, m_ramp;
    int q[$];
    bit m_ramp_act, m_uf;
    int s1_code, s2_code;
    bit s1_upd, s2_upd;

    function automatic void model_reset();
        q.delete();
        m_cnt = 0; m_period = 1; m_ramp = 0; m_ramp_act = 0; m_uf = 0;
        s1_code = 0; s2_code = 0; s1_upd = 0; s2_upd = 0;
    endfunction

    function automatic bit m_is_stream();
        return !(mode == 2'd1 || mode == 2'd2);
    endfunction

    function automatic bit m_strobe();
        return en && (m_cnt == m_period - 1);
    endfunction

    function automatic bit model_ready();
        return rstb && en && (q.size() < DEPTH || (m_strobe() && m_is_stream() && q.size() > 0));
    endfunction

    // Expected outputs: bin = code mod 128, therm = 2**(code/128)-1, complements inverted.
    function automatic logic [59:0] exp_vec();
        logic [6:0]  b;
        logic [16:0] t;
        b = 7'(s2_code % 128);
        t = 17'((1 << (s2_code / 128)) - 1);
        return {10'(s2_code), s2_upd, m_uf, b, ~b, t, ~t};
    endfunction

    // Advance one clock; the model consumes the inputs held across the edge.
    task automatic tick();
        bit st, stream, push_ok, uf_set;
        st      = m_strobe();
        stream  = m_is_stream();
        push_ok = s_valid && model_ready();
        uf_set  = st && stream && (q.size() == 0);
        @(posedge clkin);
        s2_code = s1_code;
        s2_upd  = s1_upd;
        if (!en) begin
            q.delete();
            m_cnt = 0;
            m_period = (div_ratio == 0) ? 1 : int'(div_ratio);
            m_ramp = 0; m_ramp_act = 0; s1_code = 0; s1_upd = 0;
        end else begin
            s1_upd = 0;
            if (st) begin
                m_cnt = 0;
                m_period = (div_ratio == 0) ? 1 : int'(div_ratio);
                if (mode == 2'd1) begin
                    if (!m_ramp_act) m_ramp = 0;
                    s1_code = m_ramp; s1_upd = 1;
                    m_ramp = (m_ramp + 1) % 1024;
                    m_ramp_act = 1;
                end else begin
                    m_ramp_act = 0;
                    if (mode == 2'd2) begin
                        s1_code = int'(const_code); s1_upd = 1;
                    end else if (q.size() > 0) begin
                        s1_code = q.pop_front(); s1_upd = 1;
                    end
                end
            end else begin
                m_cnt++;
            end
            if (push_ok) q.push_back(int'(s_code));
        end
        if (uf_set) m_uf = 1;
        else if (clr_flags) m_uf = 0;
        @(negedge clkin);
    endtask

    task automatic test_reset();
        rstb = 0; en = 1; mode = 0; div_ratio = 4; const_code = 0;
        s_valid = 0; s_code = 0; clr_flags = 0;
        model_reset();
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_en: got %b want 0", s_ready); end
        @(negedge clkin); @(negedge clkin);
        en = 0;
        n_cmp++; if (datainbin !== 7'h00) begin n_fail++; $display("FAIL reset_bin: got %h want 00", datainbin); end
        n_cmp++; if (datainbinb !== 7'h7F) begin n_fail++; $display("FAIL reset_binb: got %h want 7f", datainbinb); end
        n_cmp++; if (dataintherm !== 17'h0) begin n_fail++; $display("FAIL reset_therm: got %h want 0", dataintherm); end
        n_cmp++; if (datainthermb !== 17'h1FFFF) begin n_fail++; $display("FAIL reset_thermb: got %h want 1ffff", datainthermb); end
        n_cmp++; if (code_out !== 10'h0 || upd !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_code: got code=%h upd=%b uf=%b want 0/0/0", code_out, upd, underflow);
        end
        rstb = 1;
        tick(); tick();
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_idle: got %b want 0", s_ready); end
        n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_vec: got %h want %h", got_vec, exp_vec()); end
        $display("reset: done");
    endtask

    task automatic test_stream();
        int last_upd = -1;
        mode = 0; div_ratio = 4; en = 0; s_valid = 0;
        tick();
        en = 1;
        for (int i = 0; i < 14; i++) begin
            s_valid = (i < 3);
            s_code  = (i == 0) ? 10'h000 : (i == 1) ? 10'h3FF : 10'h2A5;
            #1;
            n_cmp++; if (s_ready !== model_ready()) begin n_fail++; $display("FAIL stream_ready c%0d: got %b want %b", i, s_ready, model_ready()); end
            tick();
            n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL stream_vec c%0d: got %h want %h", i, got_vec, exp_vec()); end
            n_cmp++; if (upd !== (i == 4 || i == 8 || i == 12)) begin n_fail++; $display("FAIL stream_upd_time c%0d: got %b", i, upd); end
            if (upd) begin
                if (last_upd >= 0) begin
                    n_cmp++; if (i - last_upd != 4) begin n_fail++; $display("FAIL stream_upd_gap: got %0d want 4", i - last_upd); end
                end
                last_upd = i;
            end
            if (i == 9) begin
                n_cmp++; if (code_out !== 10'h3FF || datainbin !== 7'h7F || dataintherm !== 17'h0007F) begin
                    n_fail++; $display("FAIL stream_3ff: got code=%h bin=%h therm=%h", code_out, datainbin, dataintherm);
                end
            end
            if (i == 13) begin
                n_cmp++; if (code_out !== 10'h2A5 || datainbin !== 7'h25 || dataintherm !== 17'h0001F) begin
                    n_fail++; $display("FAIL stream_2a5: got code=%h bin=%h therm=%h", code_out, datainbin, dataintherm);
                end
            end
            $display("stream c%0d: code=%h upd=%b", i, code_out, upd);
        end
        s_valid = 0;
    endtask

    task automatic test_underflow();
        bit hit = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL uf_vec c%0d: got %h want %h", i, got_vec, exp_vec()); end
        end
        n_cmp++; if (underflow !== 1'b1 || code_out !== 10'h2A5) begin
            n_fail++; $display("FAIL uf_hold: got uf=%b code=%h want 1/2a5", underflow, code_out);
        end
        if (m_strobe()) tick();
        clr_flags = 1; tick(); clr_flags = 0;
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b want 0", underflow); end
        for (int i = 0; i < 10 && !hit; i++) begin
            if (m_strobe()) begin
                hit = 1;
                clr_flags = 1;
            end
            tick();
            clr_flags = 0;
            n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL uf_vec2 c%0d: got %h want %h", i, got_vec, exp_vec()); end
        end
        n_cmp++; if (!hit || underflow !== 1'b1) begin
            n_fail++; $display("FAIL uf_set_priority: got uf=%b strobe_seen=%b want 1/1", underflow, hit);
        end
        $display("underflow: uf=%b", underflow);
    endtask

    task automatic test_ramp();
        logic [9:0] prev_code, nxt;
        prev_code = '0;
        en = 0; tick();
        mode = 1; div_ratio = 1; tick();
        en = 1;
        for (int i = 0; i < 1030; i++) begin
            tick();
            n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL ramp_vec c%0d: got %h want %h", i, got_vec, exp_vec()); end
            n_cmp++; if ((datainbin ^ datainbinb) !== 7'h7F || (dataintherm ^ datainthermb) !== 17'h1FFFF) begin
                n_fail++; $display("FAIL ramp_compl c%0d: got bin^binb=%h therm^thermb=%h", i, datainbin ^ datainbinb, dataintherm ^ datainthermb);
            end
            n_cmp++; if (dataintherm[16:7] !== 10'h0) begin n_fail++; $display("FAIL ramp_spare c%0d: got %h want 0", i, dataintherm[16:7]); end
            if (i >= 2) begin
                nxt = prev_code + 10'd1;
                n_cmp++; if (code_out !== nxt) begin n_fail++; $display("FAIL ramp_step c%0d: got %h want %h", i, code_out, nxt); end
            end
            prev_code = code_out;
            if (i % 128 == 0 || i > 1022) $display("ramp c%0d: code=%h", i, code_out);
        end
    endtask

    task automatic test_full();
        bit was_strobe;
        en = 0; mode = 0; div_ratio = 100; s_valid = 0; tick();
        en = 1;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_code = 10'($urandom_range(0, 1023));
            #1;
            n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_ready c%0d: got %b want 1", i, s_ready); end
            tick();
        end
        s_valid = 0; #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", s_ready); end
        for (int i = 0; i < 300; i++) begin
            s_valid = 1; s_code = 10'($urandom_range(0, 1023));
            #1;
            was_strobe = m_strobe();
            n_cmp++; if (s_ready !== model_ready()) begin n_fail++; $display("FAIL full_ready_m c%0d: got %b want %b", i, s_ready, model_ready()); end
            if (was_strobe) begin
                n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ready: got %b want 1", s_ready); end
            end
            tick();
            n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL full_vec c%0d: got %h want %h", i, got_vec, exp_vec()); end
            if (was_strobe) begin
                n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_count_kept: got ready=%b want 0", s_ready); end
                $display("full: push+pop at c%0d code=%h", i, s_code);
            end
        end
        s_valid = 0;
        for (int i = 0; i < 450; i++) begin
            tick();
            n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL full_drain c%0d: got %h want %h", i, got_vec, exp_vec()); end
            if (upd) $display("full drain: code=%h", code_out);
        end
    endtask

    task automatic test_en_drop();
        int first_code = 0;
        en = 0; mode = 0; div_ratio = 4; tick();
        en = 1;
        for (int i = 0; i < 6; i++) begin
            s_valid = (i < 4);
            s_code  = 10'($urandom_range(1, 1023));
            if (i == 0) first_code = int'(s_code);
            tick();
            n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL drop_vec c%0d: got %h want %h", i, got_vec, exp_vec()); end
        end
        s_valid = 0;
        n_cmp++; if (code_out !== 10'(first_code)) begin n_fail++; $display("FAIL drop_first: got %h want %h", code_out, first_code); end
        en = 0;
        tick(); tick();
        n_cmp++; if (code_out !== 10'h0 || datainbin !== 7'h0 || datainbinb !== 7'h7F || dataintherm !== 17'h0 || datainthermb !== 17'h1FFFF) begin
            n_fail++; $display("FAIL drop_zero: got code=%h bin=%h binb=%h therm=%h thermb=%h", code_out, datainbin, datainbinb, dataintherm, datainthermb);
        end
        n_cmp++; if (s_ready !== 1'b0 || underflow !== 1'b1) begin
            n_fail++; $display("FAIL drop_ready_uf: got ready=%b uf=%b want 0/1", s_ready, underflow);
        end
        clr_flags = 1; tick(); clr_flags = 0;
        en = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL reen_vec c%0d: got %h want %h", i, got_vec, exp_vec()); end
            n_cmp++; if (code_out !== 10'h0 || upd !== 1'b0) begin n_fail++; $display("FAIL reen_code c%0d: got code=%h upd=%b", i, code_out, upd); end
        end
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL reen_uf: got %b want 1", underflow); end
        $display("en_drop: code=%h uf=%b", code_out, underflow);
    endtask

    task automatic test_mix();
        for (int i = 0; i < 400; i++) begin
            if (i % 6 == 0) mode = 2'($urandom_range(0, 3));
            if (i % 9 == 0) div_ratio = 16'($urandom_range(0, 3));
            en         = ($urandom_range(0, 39) != 0);
            s_valid    = $urandom_range(0, 1);
            s_code     = 10'($urandom_range(0, 1023));
            const_code = 10'($urandom_range(0, 1023));
            clr_flags  = ($urandom_range(0, 7) == 0);
            #1;
            n_cmp++; if (s_ready !== model_ready()) begin n_fail++; $display("FAIL mix_ready c%0d: got %b want %b", i, s_ready, model_ready()); end
            tick();
            n_cmp++; if (got_vec !== exp_vec()) begin n_fail++; $display("FAIL mix_vec c%0d: got %h want %h", i, got_vec, exp_vec()); end
            if (upd) $display("mix c%0d: mode=%0d code=%h", i, mode, code_out);
        end
        clr_flags = 0; s_valid = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underflow();
        test_ramp();
        test_full();
        test_en_drop();
        test_mix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
